// File: rtl/cdc_4phase_tx_feeder.sv
// Source-domain FIFO feeding a 4-phase CDC handshake synchronizer.
// Ports: i_clk/i_rst/i_flush, s_* producer ready/valid, i_busy from
// the synchronizer, o_valid/o_data to it, o_level/o_afull/o_empty status.
module cdc_4phase_tx_feeder #(
   parameter int data_width  = 8,
   parameter int depth       = 8,
   parameter int afull_level = 6
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_flush,
   input  logic                     s_valid,
   input  logic [data_width-1:0]    s_data,
   output logic                     s_ready,
   input  logic                     i_busy,
   output logic                     o_valid,
   output logic [data_width-1:0]    o_data,
   output logic [$clog2(depth):0]   o_level,
   output logic                     o_afull,
   output logic                     o_empty
);

   localparam int aw = $clog2(depth);
   localparam logic [aw:0] ptr_one  = {{aw{1'b0}}, 1'b1};
   localparam logic [aw:0] afull_lv = afull_level[aw:0];

   logic [aw:0]           wr_ptr_q, wr_ptr_d;
   logic [aw:0]           rd_ptr_q, rd_ptr_d;
   logic [data_width-1:0] mem_q [depth];
   logic [aw:0]           level;
   logic                  full, empty, push, pop;

   assign empty = (wr_ptr_q == rd_ptr_q);
   // Wrap bits differ, index bits match: writer is one lap ahead.
   assign full  = (wr_ptr_q[aw] != rd_ptr_q[aw]) &&
                  (wr_ptr_q[aw-1:0] == rd_ptr_q[aw-1:0]);
   assign level = wr_ptr_q - rd_ptr_q;

   // Full is judged before any same-cycle pop: no pass-through.
   assign s_ready = ~full & ~i_rst & ~i_flush;
   // Each word is shown for one cycle; the synchronizer raises busy
   // on the next cycle, which blocks the following word.
   assign o_valid = ~empty & ~i_busy & ~i_rst & ~i_flush;
   assign o_data  = mem_q[rd_ptr_q[aw-1:0]];

   assign push = s_valid & s_ready;
   assign pop  = o_valid;

   assign o_level = level;
   assign o_empty = empty;
   assign o_afull = (level >= afull_lv);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (i_flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + ptr_one;
         if (pop)  rd_ptr_d = rd_ptr_q + ptr_one;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage carries no reset; push is already masked by i_rst.
   always_ff @(posedge i_clk) begin
      if (push) mem_q[wr_ptr_q[aw-1:0]] <= s_data;
   end

endmodule

// File: tb/tb_cdc_4phase_tx_feeder.sv
// Randomized self-checking bench for cdc_4phase_tx_feeder with a queue
// model of the FIFO and a simple busy-counter synchronizer model.
module tb_cdc_4phase_tx_feeder;

   logic       clk = 1'b0;
   logic       rst, flush, s_valid, s_ready;
   logic [7:0] s_data;
   logic       busy, o_valid;
   logic [7:0] o_data;
   logic [3:0] o_level;
   logic       o_afull, o_empty;

   int checks = 0;
   int failures = 0;

   logic [7:0] q[$];
   logic [7:0] sent[$];
   logic [7:0] got[$];
   int  sync_cnt = 0;
   int  busy_len = 6;
   bit  busy_force = 0;
   bit  busy_rand = 0;
   int  max_lvl = 0;

   always #5 clk = ~clk;

   cdc_4phase_tx_feeder #(
      .data_width(8), .depth(8), .afull_level(6)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_flush(flush),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .i_busy(busy), .o_valid(o_valid), .o_data(o_data),
      .o_level(o_level), .o_afull(o_afull), .o_empty(o_empty)
   );

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step(bit sv, logic [7:0] sd);
      bit er, ev;
      s_valid = sv;
      s_data  = sd;
      busy = busy_force || (sync_cnt > 0) ||
             (busy_rand && ($urandom_range(0, 1) == 1));
      #1;
      er = !rst && !flush && (q.size() < 8);
      ev = !rst && !flush && (q.size() > 0) && !busy;
      check("s_ready", {31'd0, s_ready}, {31'd0, er});
      check("o_valid", {31'd0, o_valid}, {31'd0, ev});
      if (ev) check("o_data", {24'd0, o_data}, {24'd0, q[0]});
      check("o_level", {28'd0, o_level}, q.size());
      check("o_empty", {31'd0, o_empty}, {31'd0, q.size() == 0});
      check("o_afull", {31'd0, o_afull}, {31'd0, q.size() >= 6});
      if (int'(o_level) > max_lvl) max_lvl = int'(o_level);
      if (o_valid === 1'b1) got.push_back(o_data);
      if (o_valid === 1'b1) sync_cnt = busy_len;
      else if (sync_cnt > 0) sync_cnt--;
      if (rst || flush) q.delete();
      else begin
         if (ev) void'(q.pop_front());
         if (sv && er) begin
            q.push_back(sd);
            sent.push_back(sd);
         end
      end
      @(negedge clk);
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; s_valid = 1'b1;
      s_data = 8'h11; busy = 1'b0;
      @(negedge clk);
      step(1'b1, 8'h22);
      rst = 1'b0;

      sent.delete(); got.delete();
      step(1'b1, 8'hA5);
      idle(10);
      check("single_cnt", got.size(), 1);
      if (got.size() > 0) check("single_data", {24'd0, got[0]}, 32'hA5);

      sent.delete(); got.delete();
      busy_force = 1;
      for (int i = 1; i <= 9; i++) step(1'b1, 8'(i));
      check("burst_level", {28'd0, o_level}, 8);
      check("burst_acc", sent.size(), 8);

      busy_force = 0;
      idle(70);
      check("drain_cnt", got.size(), 8);
      for (int i = 0; i < 8 && i < got.size(); i++)
         check("drain_ord", {24'd0, got[i]}, i + 1);
      check("drain_empty", {31'd0, o_empty}, 1);

      sent.delete(); got.delete();
      busy_rand = 1; max_lvl = 0;
      for (int i = 0; i < 2000 && sent.size() < 20; i++)
         step(1'(($urandom_range(0, 3) != 0)), 8'($urandom));
      busy_rand = 0;
      idle(200);
      check("rand_sent", sent.size(), 20);
      check("rand_got", got.size(), sent.size());
      for (int i = 0; i < sent.size() && i < got.size(); i++)
         check("rand_ord", {24'd0, got[i]}, {24'd0, sent[i]});
      check("rand_maxlvl", {31'd0, max_lvl <= 8}, 1);

      busy_force = 1;
      for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h40 + i));
      check("flush_full", {28'd0, o_level}, 8);
      sent.delete(); got.delete();
      flush = 1'b1;
      step(1'b1, 8'h77);
      flush = 1'b0;
      check("flush_lvl", {28'd0, o_level}, 0);
      busy_force = 0;
      idle(10);
      check("flush_quiet", got.size(), 0);
      step(1'b1, 8'h3C);
      idle(10);
      check("post_cnt", got.size(), 1);
      if (got.size() > 0) check("post_data", {24'd0, got[0]}, 32'h3C);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cdc_4phase_tx_feeder.md
Name: cdc_4phase_tx_feeder

Overview:
- Source-domain buffer directly upstream of the 4-phase CDC handshake synchronizer.
- Accepts a ready/valid word stream from producer logic and stores it in a small FIFO.
- Presents one word at a time to the synchronizer's i_valid/i_data pair, and only when the synchronizer's busy output is low.
- Lets the producer burst at full rate while the synchronizer completes its slow req/ack round trip per word.

Parameters:
data_width, 8, word width; must match the synchronizer's data width.
depth, 8, FIFO entries; power of two, minimum 2.
afull_level, 6, level at or above which o_afull is asserted; range 1..depth.

Ports:
i_clk  input  1  source-domain clock; same clock as the synchronizer's i_clk.
i_rst  input  1  reset, synchronous, active-high.
i_flush  input  1  synchronous FIFO clear.
s_valid  input  1  producer word valid.
s_data  input  data_width  producer word.
s_ready  output  1  feeder can accept a word this cycle.
i_busy  input  1  synchronizer busy output; its combinational busy, driven from the synchronizer's state register.
o_valid  output  1  drives the synchronizer's i_valid.
o_data  output  data_width  drives the synchronizer's i_data.
o_level  output  $clog2(depth)+1  current FIFO occupancy.
o_afull  output  1  o_level >= afull_level.
o_empty  output  1  FIFO empty.

Behaviour:
- Clocking and reset: single clock i_clk; reset is synchronous and active-high on i_rst.
- Reset values:
  - Read/write pointers = 0, o_level = 0, o_empty = 1, o_afull = 0.
  - o_valid = 0 and s_ready = 0 combinationally whenever i_rst = 1.
  - Storage array is not reset.
- Push:
  - s_ready = ~full & ~i_rst & ~i_flush.
  - A word is written on a rising edge where s_valid & s_ready.
  - Full is evaluated before any same-cycle pop. When full, s_ready = 0 even if a pop occurs that cycle; there is no full-pass-through.
- Pop / send:
  - o_valid = ~empty & ~i_busy & ~i_rst & ~i_flush, purely combinational.
  - o_data = FIFO head, combinational from storage at the read pointer. It is stable whenever o_valid = 1.
  - Pop (read pointer increment) occurs on the same edge as o_valid = 1. The synchronizer captures i_data on that same edge and raises busy the following cycle, so each word is presented for exactly one cycle.
- Latency:
  - A word pushed into an empty FIFO becomes visible at the head one cycle later; there is no bypass.
  - Minimum producer-to-o_valid latency is 1 cycle.
  - Back-to-back sends are spaced by the synchronizer's handshake duration, because i_busy gates every send.
- Simultaneous push and pop (not full, not empty): level is unchanged and both pointers advance.
- Pointers: log2(depth)+1 bits each, wrapping modulo 2*depth.
  - Full = MSBs differ and remaining bits are equal.
  - Empty = pointers equal.
  - o_level = write pointer − read pointer, modulo 2*depth.
- Flush:
  - i_flush = 1 sets both pointers to 0 on the next edge, discarding contents.
  - s_ready and o_valid are 0 during the flush cycle.
  - Priority order: i_rst > i_flush > push/pop.
- Mid-handshake reset or flush:
  - Feeder state clears.
  - A word already captured by the synchronizer still completes its handshake in the synchronizer.
  - The feeder sends nothing further until i_busy = 0 and the FIFO is non-empty.
- No state machine beyond FIFO pointers. All outputs except o_valid, o_data and s_ready are registered or derived from registered pointers.

Test Plan:
- Reset: i_rst high for 2 cycles with s_valid = 1 → s_ready = 0, o_valid = 0, o_level = 0, o_empty = 1. After release, s_ready = 1 on the first cycle.
- Single word: push 0xA5 with i_busy = 0 → o_valid = 1 with o_data = 0xA5 one cycle later, for exactly one cycle. Bench model then drives busy high → o_level returns to 0.
- Burst to full: depth = 8, i_busy held 1, push 0x01..0x09 on consecutive cycles:
  - 0x01..0x08 accepted.
  - s_ready = 0 on the 9th push.
  - o_level = 8.
  - o_afull = 1 from level 6 onward.
- Drain ordering: release i_busy with a bench synchronizer model (busy for 6 cycles per word) → o_data sequence is 0x01..0x08 in order, each as a single-cycle o_valid. Total of 8 pulses; o_empty = 1 at end.
- Wrap-around with concurrent push/pop: 20 random words through depth 8 with random s_valid and i_busy → output order equals input order, no loss or duplication. o_level never exceeds 8.
- Flush while full and busy: assert i_flush for 1 cycle → o_level = 0 next cycle, o_valid stays 0 after busy drops. A new push of 0x3C is then sent as the next word.
